// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter
// Brief   : Round-robin arbiter sharing one single-outstanding memory bus port
//           between NUM_REQ masters. Define MEM_ARB_TIMEOUT_EN for a WAIT watchdog.
// Revision: 1.0
// ============================================================================

module mem_bus_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [32*NUM_REQ-1:0]      i_req_address,
  input  logic [32*NUM_REQ-1:0]      i_req_data,
  input  logic [3*NUM_REQ-1:0]       i_req_bhw,
  input  logic [NUM_REQ-1:0]         i_req_write,
  output logic [NUM_REQ-1:0]         o_ack,
  output logic [31:0]                o_rdata,
  output logic                       o_err,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_busy,
  output logic [31:0]                o_bus_data,
  output logic [31:0]                o_bus_address,
  output logic                       o_bus_DV,
  output logic [2:0]                 o_bhw,
  output logic                       o_write_notread,
  input  logic [31:0]                i_bus_data,
  input  logic                       i_bus_DV
);

  localparam int c_id_w = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_params
    $error("mem_bus_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES in [1, 65536]");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_id_w-1:0]   r_ptr;
  logic [c_id_w-1:0]   r_grant_id;
  logic [31:0]         r_bus_address;
  logic [31:0]         r_bus_data;
  logic [2:0]          r_bhw;
  logic                r_write;
  logic [31:0]         r_rdata;
  logic                r_err;

  logic [c_id_w-1:0]   w_winner;
  logic [c_id_w-1:0]   w_ptr_nxt;
  logic                w_found;
  logic [31:0]         w_win_addr;
  logic [31:0]         w_win_data;
  logic [2:0]          w_win_bhw;
  logic                w_win_wr;
  logic                w_bhw_ok;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] c_wdog_last = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_wdog;
  logic        w_wdog_expired;
  assign w_wdog_expired = (r_wdog == c_wdog_last);
`endif

  // Wrap-around index: base + offset modulo NUM_REQ, offset < NUM_REQ.
  function automatic logic [c_id_w-1:0] rr_index(input logic [c_id_w-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return c_id_w'(sum);
  endfunction

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[rr_index(r_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = rr_index(r_ptr, k);
      end
    end
  end

  assign w_win_addr = i_req_address[32*int'(w_winner) +: 32];
  assign w_win_data = i_req_data[32*int'(w_winner) +: 32];
  assign w_win_bhw  = i_req_bhw[3*int'(w_winner) +: 3];
  assign w_win_wr   = i_req_write[w_winner];
  // A size code the memory side cannot decode (e.g. 000) would hang it.
  assign w_bhw_ok   = (w_win_bhw == 3'b100) || (w_win_bhw == 3'b010) || (w_win_bhw == 3'b001);
  assign w_ptr_nxt  = (w_winner == c_id_w'(NUM_REQ - 1)) ? '0 : w_winner + c_id_w'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_bus_DV    = 1'b0;
    o_busy      = 1'b1;
    o_ack       = '0;
    o_err       = 1'b0;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (|i_req) w_state_nxt = w_bhw_ok ? ISSUE : DONE;
      end
      ISSUE: begin
        o_bus_DV    = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (i_bus_DV) w_state_nxt = DONE;
`ifdef MEM_ARB_TIMEOUT_EN
        else if (w_wdog_expired) w_state_nxt = DONE;
`endif
      end
      DONE: begin
        o_ack       = NUM_REQ'(1) << r_grant_id;
        o_err       = r_err;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr         <= '0;
      r_grant_id    <= '0;
      r_bus_address <= '0;
      r_bus_data    <= '0;
      r_bhw         <= '0;
      r_write       <= 1'b0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_wdog        <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (|i_req) begin
            r_bus_address <= w_win_addr;
            r_bus_data    <= w_win_data;
            r_bhw         <= w_win_bhw;
            r_write       <= w_win_wr;
            r_grant_id    <= w_winner;
            r_ptr         <= w_ptr_nxt;
            r_err         <= !w_bhw_ok;
            if (!w_bhw_ok) r_rdata <= '0;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        ISSUE: r_wdog <= '0;
`endif
        WAIT: begin
          if (i_bus_DV) begin
            r_rdata <= r_write ? 32'd0 : i_bus_data;
            r_err   <= 1'b0;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (w_wdog_expired) begin
            r_rdata <= 32'hDEADBEEF;
            r_err   <= 1'b1;
          end else begin
            r_wdog  <= r_wdog + 16'd1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign o_rdata         = r_rdata;
  assign o_grant_id      = r_grant_id;
  assign o_bus_address   = r_bus_address;
  assign o_bus_data      = r_bus_data;
  assign o_bhw           = r_bhw;
  assign o_write_notread = r_write;

endmodule

`default_nettype wire
